// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control unit: opcodes, ALU selects,
// sequencer states and instruction-register field positions.
package cpu_defs;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_NEG   = 4'd4,
    ALU_NOT   = 4'd5,
    ALU_SHR   = 4'd6,
    ALU_SHRA  = 4'd7,
    ALU_SHL   = 4'd8,
    ALU_ROR   = 4'd9,
    ALU_ROL   = 4'd10,
    ALU_MUL   = 4'd11,
    ALU_DIV   = 4'd12,
    ALU_INCPC = 4'd13,
    ALU_NONE  = 4'd14
  } alu_op_t;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    CLS_THREE, CLS_UNARY, CLS_MULDIV, CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/control_decode.sv
// Opcode decoder: classifies an instruction and picks its ALU operation.
module control_decode
  import cpu_defs::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t instr_class,
  output alu_op_t      alu_op
);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    alu_op      = ALU_NONE;
    case (opcode)
      OP_ADD:  begin instr_class = CLS_THREE;  alu_op = ALU_ADD;  end
      OP_SUB:  begin instr_class = CLS_THREE;  alu_op = ALU_SUB;  end
      OP_AND:  begin instr_class = CLS_THREE;  alu_op = ALU_AND;  end
      OP_OR:   begin instr_class = CLS_THREE;  alu_op = ALU_OR;   end
      OP_SHR:  begin instr_class = CLS_THREE;  alu_op = ALU_SHR;  end
      OP_SHRA: begin instr_class = CLS_THREE;  alu_op = ALU_SHRA; end
      OP_SHL:  begin instr_class = CLS_THREE;  alu_op = ALU_SHL;  end
      OP_ROR:  begin instr_class = CLS_THREE;  alu_op = ALU_ROR;  end
      OP_ROL:  begin instr_class = CLS_THREE;  alu_op = ALU_ROL;  end
      OP_MUL:  begin instr_class = CLS_MULDIV; alu_op = ALU_MUL;  end
      OP_DIV:  begin instr_class = CLS_MULDIV; alu_op = ALU_DIV;  end
      OP_NEG:  begin instr_class = CLS_UNARY;  alu_op = ALU_NEG;  end
      OP_NOT:  begin instr_class = CLS_UNARY;  alu_op = ALU_NOT;  end
      default: begin instr_class = CLS_ILLEGAL; alu_op = ALU_NONE; end
    endcase
  end

endmodule

// File: rtl/hardwired_control_unit.sv
// Fetch/execute T-state sequencer driving the datapath strobes for
// register-format ALU instructions, with fetch stall and illegal-opcode halt.
module hardwired_control_unit
  import cpu_defs::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                ZLowout,
  output logic                ZHighout,
  output logic                MDRout,
  output logic                Rout,
  output logic                PCin,
  output logic                MARin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Rin,
  output logic                HIin,
  output logic                LOin,
  output logic                read,
  output logic [3:0]          ALU_operation,
  output logic [3:0]          reg_select,
  output logic                busy,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired
);

  state_t       state;
  instr_class_t instr_class;
  alu_op_t      dec_alu;
  alu_op_t      alu_sel;
  logic [3:0]   ra, rb, rc;
  logic         last_state;
  logic         unused_ir_bits;

  assign ra = ir[RA_MSB:RA_LSB];
  assign rb = ir[RB_MSB:RB_LSB];
  assign rc = ir[RC_MSB:RC_LSB];
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  control_decode u_decode (
    .opcode      (ir[OPC_MSB:OPC_LSB]),
    .instr_class (instr_class),
    .alu_op      (dec_alu)
  );

  // The final T-state depends on class: unary ends at T4, three-operand at T5, mul/div at T6.
  assign last_state = (state == S_T4 && instr_class == CLS_UNARY) ||
                      (state == S_T5 && instr_class == CLS_THREE) ||
                      (state == S_T6);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_IDLE;
      retired <= '0;
    end else if (last_state) begin
      retired <= retired + RETIRE_W'(1);
      state   <= run ? S_T0 : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (run) state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    if (mem_ready) state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= (instr_class == CLS_ILLEGAL) ? S_HALT : S_T4;
        S_T4:    state <= S_T5;
        S_T5:    state <= S_T6;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (state != S_IDLE) && (state != S_HALT);
  assign fault         = (state == S_HALT);
  assign ALU_operation = alu_sel;

  // Strobes decode straight from state so an asynchronous clear drops them at once.
  always_comb begin
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0; Rout = 1'b0;
    PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Rin = 1'b0; HIin = 1'b0; LOin = 1'b0; read = 1'b0;
    alu_sel    = ALU_NONE;
    reg_select = 4'd0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; alu_sel = ALU_INCPC; end
      S_T1: begin ZLowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (instr_class)
          CLS_THREE:  begin Rout = 1'b1; reg_select = rb; Yin = 1'b1; end
          CLS_UNARY:  begin Rout = 1'b1; reg_select = rb; alu_sel = dec_alu; Zin = 1'b1; end
          CLS_MULDIV: begin Rout = 1'b1; reg_select = ra; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (instr_class)
          CLS_THREE:  begin Rout = 1'b1; reg_select = rc; alu_sel = dec_alu; Zin = 1'b1; end
          CLS_UNARY:  begin ZLowout = 1'b1; Rin = 1'b1; reg_select = ra; end
          CLS_MULDIV: begin Rout = 1'b1; reg_select = rb; alu_sel = dec_alu; Zin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        if (instr_class == CLS_THREE) begin
          ZLowout = 1'b1; Rin = 1'b1; reg_select = ra;
        end else if (instr_class == CLS_MULDIV) begin
          ZLowout = 1'b1; LOin = 1'b1;
        end
      end
      S_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Directed bench for hardwired_control_unit: walks reset, fetch stall,
// each instruction class and the illegal-opcode halt with hand-computed strobes.
module tb_hardwired_control_unit;

  localparam logic [14:0] B_PCOUT    = 15'h4000;
  localparam logic [14:0] B_ZLOWOUT  = 15'h2000;
  localparam logic [14:0] B_ZHIGHOUT = 15'h1000;
  localparam logic [14:0] B_MDROUT   = 15'h0800;
  localparam logic [14:0] B_ROUT     = 15'h0400;
  localparam logic [14:0] B_PCIN     = 15'h0200;
  localparam logic [14:0] B_MARIN    = 15'h0100;
  localparam logic [14:0] B_MDRIN    = 15'h0080;
  localparam logic [14:0] B_IRIN     = 15'h0040;
  localparam logic [14:0] B_YIN      = 15'h0020;
  localparam logic [14:0] B_ZIN      = 15'h0010;
  localparam logic [14:0] B_RIN      = 15'h0008;
  localparam logic [14:0] B_HIIN     = 15'h0004;
  localparam logic [14:0] B_LOIN     = 15'h0002;
  localparam logic [14:0] B_READ     = 15'h0001;

  localparam logic [14:0] M_T0 = B_PCOUT | B_MARIN | B_ZIN;
  localparam logic [14:0] M_T1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [14:0] M_T2 = B_MDROUT | B_IRIN;

  localparam logic [31:0] IR_SHRA = 32'h2B82_0000;
  localparam logic [31:0] IR_MUL  = 32'h7918_0000;
  localparam logic [31:0] IR_NOT  = 32'h90A8_0000;
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;

  logic        clock;
  logic        clear;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;
  logic PCout, ZLowout, ZHighout, MDRout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin, read;
  logic [3:0]  ALU_operation;
  logic [3:0]  reg_select;
  logic        busy;
  logic        fault;
  logic [15:0] retired;
  logic [14:0] strobes;

  int passed = 0;
  int total  = 0;
  int ir_pulses;

  hardwired_control_unit #(.RETIRE_W(16)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout), .Rout(Rout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Rin(Rin), .HIin(HIin), .LOin(LOin), .read(read),
    .ALU_operation(ALU_operation), .reg_select(reg_select),
    .busy(busy), .fault(fault), .retired(retired)
  );

  assign strobes = {PCout, ZLowout, ZHighout, MDRout, Rout, PCin, MARin, MDRin,
                    IRin, Yin, Zin, Rin, HIin, LOin, read};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [14:0] exp_strobes,
                              input logic [3:0] exp_alu, input logic [3:0] exp_reg,
                              input logic exp_busy);
    check({tag, ".strobes"}, 32'(strobes), 32'(exp_strobes));
    check({tag, ".alu"}, 32'(ALU_operation), 32'(exp_alu));
    check({tag, ".reg"}, 32'(reg_select), 32'(exp_reg));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic apply_stimulus(input logic r, input logic m, input logic [31:0] i);
    run       = r;
    mem_ready = m;
    ir        = i;
  endtask

  // Each step lands mid-cycle, where the bus-drive exclusivity is also checked.
  task automatic step();
    @(negedge clock);
    check("bus_onehot", 32'($countones({PCout, ZLowout, ZHighout, MDRout, Rout}) <= 1), 32'd1);
  endtask

  initial begin
    apply_stimulus(1'b1, 1'b1, IR_SHRA);
    clear = 1'b1;
    #2 clear = 1'b0;

    // Reset state
    step();
    check_output("reset", 15'h0, 4'd14, 4'd0, 1'b0);
    check("reset.fault", 32'(fault), 32'd0);
    check("reset.retired", 32'(retired), 32'd0);

    // Test 1: async clear mid-instruction
    clear = 1'b1;
    step(); check_output("t1_t0", M_T0, 4'd13, 4'd0, 1'b1);
    step(); check_output("t1_t1", M_T1, 4'd14, 4'd0, 1'b1);
    step(); check_output("t1_t2", M_T2, 4'd14, 4'd0, 1'b1);
    step(); check_output("t1_t3", B_ROUT | B_YIN, 4'd14, 4'd0, 1'b1);
    step(); check_output("t1_t4", B_ROUT | B_ZIN, 4'd7, 4'd4, 1'b1);
    #1 clear = 1'b0;
    #1 check_output("t1_async", 15'h0, 4'd14, 4'd0, 1'b0);
    check("t1_async.retired", 32'(retired), 32'd0);
    step();
    clear = 1'b1;

    // Test 2: shra R7,R0,R4
    step(); check_output("t2_t0", M_T0, 4'd13, 4'd0, 1'b1);
    step(); check_output("t2_t1", M_T1, 4'd14, 4'd0, 1'b1);
    step(); check_output("t2_t2", M_T2, 4'd14, 4'd0, 1'b1);
    step(); check_output("t2_t3", B_ROUT | B_YIN, 4'd14, 4'd0, 1'b1);
    step(); check_output("t2_t4", B_ROUT | B_ZIN, 4'd7, 4'd4, 1'b1);
    step(); check_output("t2_t5", B_ZLOWOUT | B_RIN, 4'd14, 4'd7, 1'b1);
    check("t2_t5.retired", 32'(retired), 32'd0);
    step(); check_output("t2_next_t0", M_T0, 4'd13, 4'd0, 1'b1);
    check("t2_retired", 32'(retired), 32'd1);

    // Test 3: three stall cycles in T1, then IRin exactly once
    apply_stimulus(1'b1, 1'b0, IR_SHRA);
    ir_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("t3_stall", M_T1, 4'd14, 4'd0, 1'b1);
      if (IRin) ir_pulses++;
    end
    apply_stimulus(1'b1, 1'b1, IR_MUL);
    step(); check_output("t3_t2", M_T2, 4'd14, 4'd0, 1'b1);
    if (IRin) ir_pulses++;

    // Test 4: mul with Ra=2, Rb=3
    step(); check_output("t4_t3", B_ROUT | B_YIN, 4'd14, 4'd2, 1'b1);
    if (IRin) ir_pulses++;
    check("t3_irin_once", 32'(ir_pulses), 32'd1);
    step(); check_output("t4_t4", B_ROUT | B_ZIN, 4'd11, 4'd3, 1'b1);
    step(); check_output("t4_t5", B_ZLOWOUT | B_LOIN, 4'd14, 4'd0, 1'b1);
    step(); check_output("t4_t6", B_ZHIGHOUT | B_HIIN, 4'd14, 4'd0, 1'b1);
    step(); check_output("t4_next_t0", M_T0, 4'd13, 4'd0, 1'b1);
    check("t4_retired", 32'(retired), 32'd2);

    // Test 5: not with Ra=1, Rb=5; run dropped mid-instruction
    step(); check_output("t5_t1", M_T1, 4'd14, 4'd0, 1'b1);
    step(); check_output("t5_t2", M_T2, 4'd14, 4'd0, 1'b1);
    apply_stimulus(1'b1, 1'b1, IR_NOT);
    step(); check_output("t5_t3", B_ROUT | B_ZIN, 4'd5, 4'd5, 1'b1);
    apply_stimulus(1'b0, 1'b1, IR_NOT);
    step(); check_output("t5_t4", B_ZLOWOUT | B_RIN, 4'd14, 4'd1, 1'b1);
    step(); check_output("t5_idle", 15'h0, 4'd14, 4'd0, 1'b0);
    check("t5_retired", 32'(retired), 32'd3);
    step(); check_output("t5_idle_hold", 15'h0, 4'd14, 4'd0, 1'b0);

    // Test 6: illegal opcode halts
    apply_stimulus(1'b1, 1'b1, IR_ILL);
    step(); check_output("t6_t0", M_T0, 4'd13, 4'd0, 1'b1);
    step(); check_output("t6_t1", M_T1, 4'd14, 4'd0, 1'b1);
    step(); check_output("t6_t2", M_T2, 4'd14, 4'd0, 1'b1);
    step(); check_output("t6_t3", 15'h0, 4'd14, 4'd0, 1'b1);
    check("t6_t3.fault", 32'(fault), 32'd0);
    step(); check_output("t6_halt", 15'h0, 4'd14, 4'd0, 1'b0);
    check("t6_halt.fault", 32'(fault), 32'd1);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(i[0], ~i[0], IR_SHRA);
      step();
      check_output("t6_halt_hold", 15'h0, 4'd14, 4'd0, 1'b0);
      check("t6_halt_hold.fault", 32'(fault), 32'd1);
    end
    check("t6_halt.retired", 32'(retired), 32'd3);
    #1 clear = 1'b0;
    #1 check("t6_clear.fault", 32'(fault), 32'd0);
    check("t6_clear.retired", 32'(retired), 32'd0);
    step();
    clear = 1'b1;
    apply_stimulus(1'b0, 1'b1, IR_SHRA);
    step(); check_output("t6_idle", 15'h0, 4'd14, 4'd0, 1'b0);
    apply_stimulus(1'b1, 1'b1, IR_SHRA);
    step(); check_output("t6_restart_t0", M_T0, 4'd13, 4'd0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
